// File: rtl/dffsr_pipe_if.sv
// Handshake bundle for dffsr_pipe: an input valid/ready channel, set and clear
// controls, an output valid/ready channel and the occupancy count.
// The master drives data and controls; the slave is the pipeline.
interface dffsr_pipe_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] d;
  logic             in_valid;
  logic             in_ready;
  logic             s;
  logic             c;
  logic [WIDTH-1:0] q;
  logic             out_valid;
  logic             out_ready;
  logic [OCC_W-1:0] occ;

  modport master (
    output d, in_valid, s, c, out_ready,
    input  in_ready, q, out_valid, occ
  );

  modport slave (
    input  d, in_valid, s, c, out_ready,
    output in_ready, q, out_valid, occ
  );
endinterface

// File: rtl/dffsr_pipe.sv
// dffsr_pipe: DEPTH-stage valid/ready pipeline of WIDTH-bit registers with
// bubble collapse, a synchronous set that overwrites every occupied stage,
// a synchronous clear (flush) that wins over set, and an asynchronous
// active-high reset. Q and OUT_VALID come straight from the last stage.
module dffsr_pipe #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] SET_VAL = {WIDTH{1'b1}}
) (
  input logic         clk,
  input logic         rst,
  dffsr_pipe_if.slave bus
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  // Stage 0 is the input stage, stage DEPTH-1 drives Q.
  logic [WIDTH-1:0] data_r     [DEPTH];
  logic [WIDTH-1:0] data_nxt_s [DEPTH];
  logic [DEPTH-1:0] valid_r;
  logic [DEPTH-1:0] valid_nxt_s;
  logic [DEPTH-1:0] adv_s;
  logic [OCC_W-1:0] occ_r;
  logic [OCC_W-1:0] occ_nxt_s;
  logic             in_ready_s;
  logic             in_fire_s;

  // Advance flags, walked from the output back so each stage knows whether its successor frees up this cycle.
  always_comb begin : adv_calc
    logic succ_frees;
    logic adv_i;
    adv_s      = {DEPTH{1'b0}};
    succ_frees = bus.out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      adv_i      = valid_r[i] & succ_frees;
      adv_s[i]   = adv_i;
      succ_frees = ~valid_r[i] | adv_i;
    end
  end

  // Intake readiness uses only stage occupancy and downstream readiness; held low during reset.
  always_comb begin
    if (rst) begin
      in_ready_s = 1'b0;
    end else begin
      in_ready_s = ~valid_r[0] | adv_s[0];
    end
  end

  assign in_fire_s = bus.in_valid & in_ready_s;

  // Next-state data and valid bits: movement and intake first, then clear (highest priority) or set.
  always_comb begin
    valid_nxt_s = valid_r;
    data_nxt_s  = data_r;

    // Upper stages take the entry from below when it advances, otherwise empty out or hold.
    for (int i = DEPTH - 1; i >= 1; i--) begin
      if (adv_s[i-1]) begin
        valid_nxt_s[i] = 1'b1;
        data_nxt_s[i]  = data_r[i-1];
      end else if (adv_s[i]) begin
        valid_nxt_s[i] = 1'b0;
      end else begin
        valid_nxt_s[i] = valid_r[i];
      end
    end

    // Input stage captures D on a transfer; an accepted entry always replaces a leaving one.
    if (in_fire_s) begin
      valid_nxt_s[0] = 1'b1;
      data_nxt_s[0]  = bus.d;
    end else if (adv_s[0]) begin
      valid_nxt_s[0] = 1'b0;
    end else begin
      valid_nxt_s[0] = valid_r[0];
    end

    // Clear drops every entry, including one accepted this cycle, and freezes the data registers.
    if (bus.c) begin
      valid_nxt_s = {DEPTH{1'b0}};
      data_nxt_s  = data_r;
    end else if (bus.s) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (valid_nxt_s[i]) begin
          data_nxt_s[i] = SET_VAL;
        end else begin
          data_nxt_s[i] = data_nxt_s[i];
        end
      end
    end else begin
      valid_nxt_s = valid_nxt_s;
    end
  end

  // Occupancy after this edge is the population count of the next valid bits.
  always_comb begin
    occ_nxt_s = {OCC_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      occ_nxt_s = occ_nxt_s + OCC_W'(valid_nxt_s[i]);
    end
  end

  // Pipeline state registers; reset forces data to RST_VAL and empties every stage at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_r[i] <= RST_VAL;
      end
      valid_r <= {DEPTH{1'b0}};
      occ_r   <= {OCC_W{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        data_r[i] <= data_nxt_s[i];
      end
      valid_r <= valid_nxt_s;
      occ_r   <= occ_nxt_s;
    end
  end

  assign bus.q         = data_r[DEPTH-1];
  assign bus.out_valid = valid_r[DEPTH-1];
  assign bus.occ       = occ_r;
  assign bus.in_ready  = in_ready_s;

endmodule

// File: tb/tb_dffsr_pipe.sv
// Self-checking bench for dffsr_pipe (WIDTH=8, DEPTH=2). Directed scenarios
// check fixed expectations; a randomized phase compares against a model that
// keeps the pipe contents as an ordered list of (data, stage position).
`timescale 1ns/1ps
module tb_dffsr_pipe;
  localparam int         WIDTH   = 8;
  localparam int         DEPTH   = 2;
  localparam logic [7:0] RST_VAL = 8'h00;
  localparam logic [7:0] SET_VAL = 8'hFF;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passes = 0;

  // Model: oldest entry first; mp holds the stage each entry sits in.
  logic [7:0] mq [$];
  int         mp [$];

  dffsr_pipe_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  dffsr_pipe #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .RST_VAL(RST_VAL), .SET_VAL(SET_VAL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic bit m_ov();
    return (mq.size() > 0) && (mp[0] == DEPTH - 1);
  endfunction

  // Room exists when fewer than DEPTH entries are held or the oldest one leaves now.
  function automatic bit m_ir();
    return !rst && ((mq.size() < DEPTH) || (m_ov() && bus.out_ready));
  endfunction

  // Advance the model across one rising edge using the inputs currently applied.
  task automatic model_edge();
    bit fire_out;
    bit fire_in;
    int lim;
    fire_out = m_ov() && bus.out_ready;
    fire_in  = bus.in_valid && m_ir();
    if (rst || bus.c) begin
      mq.delete();
      mp.delete();
    end else begin
      if (fire_out) begin
        void'(mq.pop_front());
        void'(mp.pop_front());
      end
      lim = DEPTH - 1;
      for (int k = 0; k < mq.size(); k++) begin
        mp[k] = (mp[k] + 1 < lim) ? mp[k] + 1 : lim;
        lim   = mp[k] - 1;
      end
      if (fire_in) begin
        mq.push_back(bus.d);
        mp.push_back(0);
      end
      if (bus.s) begin
        for (int k = 0; k < mq.size(); k++) mq[k] = SET_VAL;
      end
    end
  endtask

  task automatic drive(input logic [7:0] d, input bit v, input bit s, input bit c, input bit ordy);
    bus.d         = d;
    bus.in_valid  = v;
    bus.s         = s;
    bus.c         = c;
    bus.out_ready = ordy;
    #1;
  endtask

  task automatic tick();
    model_edge();
    @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    checks++; if (bus.q !== RST_VAL) $display("FAIL reset_q: got %h want %h", bus.q, RST_VAL); else passes++;
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_ov: got %b want 0", bus.out_valid); else passes++;
    checks++; if (bus.occ !== 2'd0) $display("FAIL reset_occ: got %0d want 0", bus.occ); else passes++;
    checks++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); else passes++;
    rst = 1'b0;
    mq.delete();
    mp.delete();
    #1;
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL release_in_ready: got %b want 1", bus.in_ready); else passes++;
  endtask

  task automatic test_stream();
    logic [7:0] din  [3];
    bit         eov  [5];
    logic [7:0] eq   [5];
    logic [1:0] eocc [5];
    din  = '{8'h11, 8'h22, 8'h33};
    eov  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    eq   = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h00};
    eocc = '{2'd1, 2'd2, 2'd2, 2'd1, 2'd0};
    for (int k = 0; k < 5; k++) begin
      if (k < 3) begin
        drive(din[k], 1'b1, 1'b0, 1'b0, 1'b1);
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL stream_in_ready[%0d]: got %b want 1", k, bus.in_ready); else passes++;
      end else begin
        drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      end
      tick();
      checks++; if (bus.out_valid !== eov[k]) $display("FAIL stream_ov[%0d]: got %b want %b", k, bus.out_valid, eov[k]); else passes++;
      if (eov[k]) begin
        checks++; if (bus.q !== eq[k]) $display("FAIL stream_q[%0d]: got %h want %h", k, bus.q, eq[k]); else passes++;
      end
      checks++; if (bus.occ !== eocc[k]) $display("FAIL stream_occ[%0d]: got %0d want %0d", k, bus.occ, eocc[k]); else passes++;
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] got [$];
    logic [7:0] exp [3];
    bit         a3_pending;
    exp = '{8'hA1, 8'hA2, 8'hA3};
    drive(8'hA1, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL bp_ready_a1: got %b want 1", bus.in_ready); else passes++;
    tick();
    drive(8'hA2, 1'b1, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL bp_ready_a2: got %b want 1", bus.in_ready); else passes++;
    tick();
    drive(8'hA3, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      checks++; if (bus.in_ready !== 1'b0) $display("FAIL bp_ready_full[%0d]: got %b want 0", k, bus.in_ready); else passes++;
      checks++; if (bus.occ !== 2'd2) $display("FAIL bp_occ[%0d]: got %0d want 2", k, bus.occ); else passes++;
      checks++; if (bus.q !== 8'hA1 || bus.out_valid !== 1'b1) $display("FAIL bp_hold[%0d]: got q=%h ov=%b want q=a1 ov=1", k, bus.q, bus.out_valid); else passes++;
      tick();
    end
    a3_pending = 1'b1;
    for (int k = 0; k < 6; k++) begin
      drive(8'hA3, a3_pending, 1'b0, 1'b0, 1'b1);
      if (bus.out_valid === 1'b1) got.push_back(bus.q);
      if (a3_pending && bus.in_ready === 1'b1) a3_pending = 1'b0;
      tick();
    end
    checks++; if (got.size() != 3) $display("FAIL bp_count: got %0d want 3", got.size()); else passes++;
    for (int k = 0; k < 3; k++) begin
      checks++; if (k >= got.size() || got[k] !== exp[k]) $display("FAIL bp_order[%0d]: got %h want %h", k, (k < got.size()) ? got[k] : 8'hxx, exp[k]); else passes++;
    end
  endtask

  task automatic test_set();
    logic [7:0] got [$];
    drive(8'h05, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(8'h06, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(8'h00, 1'b0, 1'b1, 1'b0, 1'b0); tick();
    drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++; if (bus.q !== SET_VAL || bus.out_valid !== 1'b1) $display("FAIL set_q: got q=%h ov=%b want q=ff ov=1", bus.q, bus.out_valid); else passes++;
    checks++; if (bus.occ !== 2'd2) $display("FAIL set_occ: got %0d want 2", bus.occ); else passes++;
    for (int k = 0; k < 3; k++) begin
      drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
      if (bus.out_valid === 1'b1) got.push_back(bus.q);
      tick();
    end
    checks++; if (got.size() != 2 || got[0] !== SET_VAL || got[1] !== SET_VAL) $display("FAIL set_drain: got %0d entries first %h want 2 entries of ff", got.size(), (got.size() > 0) ? got[0] : 8'hxx); else passes++;
    drive(8'h00, 1'b0, 1'b1, 1'b0, 1'b1); tick();
    drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (bus.occ !== 2'd0 || bus.out_valid !== 1'b0) $display("FAIL set_empty: got occ=%0d ov=%b want occ=0 ov=0", bus.occ, bus.out_valid); else passes++;
  endtask

  task automatic test_clear_priority();
    drive(8'h31, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(8'h32, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(8'h77, 1'b1, 1'b1, 1'b1, 1'b1);
    checks++; if (bus.occ !== 2'd2) $display("FAIL clr_pre_occ: got %0d want 2", bus.occ); else passes++;
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL clr_in_ready: got %b want 1", bus.in_ready); else passes++;
    tick();
    drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (bus.occ !== 2'd0 || bus.out_valid !== 1'b0) $display("FAIL clr_flush: got occ=%0d ov=%b want occ=0 ov=0", bus.occ, bus.out_valid); else passes++;
    for (int k = 0; k < 4; k++) begin
      checks++; if (bus.out_valid !== 1'b0 || bus.q === 8'h77) $display("FAIL clr_no77[%0d]: got q=%h ov=%b want ov=0 and q!=77", k, bus.q, bus.out_valid); else passes++;
      tick();
    end
  endtask

  task automatic test_async_reset();
    drive(8'h51, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(8'h52, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (bus.occ !== 2'd2 || bus.q !== 8'h51) $display("FAIL ar_full: got occ=%0d q=%h want occ=2 q=51", bus.occ, bus.q); else passes++;
    #1;
    rst = 1'b1;
    mq.delete();
    mp.delete();
    #1;
    checks++; if (bus.q !== RST_VAL) $display("FAIL ar_q: got %h want %h", bus.q, RST_VAL); else passes++;
    checks++; if (bus.out_valid !== 1'b0 || bus.occ !== 2'd0) $display("FAIL ar_state: got ov=%b occ=%0d want 0 0", bus.out_valid, bus.occ); else passes++;
    checks++; if (bus.in_ready !== 1'b0) $display("FAIL ar_in_ready: got %b want 0", bus.in_ready); else passes++;
    @(negedge clk);
    #1;
    drive(8'h99, 1'b1, 1'b1, 1'b0, 1'b1);
    checks++; if (bus.in_ready !== 1'b0) $display("FAIL ar_held_ready: got %b want 0", bus.in_ready); else passes++;
    tick();
    checks++; if (bus.occ !== 2'd0 || bus.out_valid !== 1'b0) $display("FAIL ar_ignored: got occ=%0d ov=%b want 0 0", bus.occ, bus.out_valid); else passes++;
    rst = 1'b0;
    drive(8'h42, 1'b1, 1'b0, 1'b0, 1'b1);
    checks++; if (bus.in_ready !== 1'b1) $display("FAIL ar_release_ready: got %b want 1", bus.in_ready); else passes++;
    tick();
    drive(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (bus.out_valid !== 1'b0) $display("FAIL ar_lat1: got ov=%b want 0", bus.out_valid); else passes++;
    tick();
    checks++; if (bus.out_valid !== 1'b1 || bus.q !== 8'h42) $display("FAIL ar_first: got q=%h ov=%b want q=42 ov=1", bus.q, bus.out_valid); else passes++;
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      drive(8'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 29) == 0), ($urandom_range(0, 9) < 6));
      checks++; if (bus.in_ready !== m_ir()) $display("FAIL rnd_in_ready[%0d]: got %b want %b", n, bus.in_ready, m_ir()); else passes++;
      checks++; if (bus.out_valid !== m_ov()) $display("FAIL rnd_ov[%0d]: got %b want %b", n, bus.out_valid, m_ov()); else passes++;
      if (m_ov()) begin
        checks++; if (bus.q !== mq[0]) $display("FAIL rnd_q[%0d]: got %h want %h", n, bus.q, mq[0]); else passes++;
      end
      checks++; if (bus.occ !== 2'(mq.size())) $display("FAIL rnd_occ[%0d]: got %0d want %0d", n, bus.occ, mq.size()); else passes++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_set();
    test_clear_priority();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/dffsr_pipe.md
DFFSR_PIPE -- requirements
Module: dffsr_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits (1..64).
REQ-002 SHALL have parameter DEPTH, default 2, number of pipeline stages (1..16).
REQ-003 SHALL have parameter RST_VAL, default all-zero WIDTH-bit value, data value loaded by reset.
REQ-004 SHALL have parameter SET_VAL, default all-ones WIDTH-bit value, data value loaded by synchronous set.
REQ-005 CLK  input  1  single clock; all state changes on rising edge, except reset.
REQ-006 R  input  1  reset; asynchronous, active-high.
REQ-007 D  input  WIDTH  input data.
REQ-008 IN_VALID  input  1  D is valid this cycle.
REQ-009 IN_READY  output  1  block accepts D this cycle.
REQ-010 S  input  1  synchronous set of all occupied stages.
REQ-011 C  input  1  synchronous clear (flush) of all stages.
REQ-012 Q  output  WIDTH  data of last stage.
REQ-013 OUT_VALID  output  1  Q is valid.
REQ-014 OUT_READY  input  1  consumer accepts Q this cycle.
REQ-015 OCC  output  $clog2(DEPTH+1)  number of occupied stages.

Function
REQ-016 Each stage i (0 = input, DEPTH-1 = output) SHALL hold a data register and a valid bit.
REQ-017 Stage DEPTH-1 SHALL advance (empty out) when OUT_VALID && OUT_READY.
REQ-018 Stage i<DEPTH-1 SHALL pass its entry to stage i+1 when stage i+1 is empty or stage i+1 advances in the same cycle (bubble collapse).
REQ-019 IN_READY SHALL equal (stage 0 empty) || (stage 0 advances this cycle); combinational from OUT_READY and valid bits only, never from IN_VALID.
REQ-020 A transfer in SHALL occur when IN_VALID && IN_READY; D SHALL be captured into stage 0.
REQ-021 Latency with OUT_READY held high and empty pipe SHALL be exactly DEPTH cycles from input transfer to OUT_VALID; throughput one entry per cycle.
REQ-022 Data order SHALL be preserved; no entry SHALL be dropped or duplicated except by C or R.
REQ-023 Q and OUT_VALID SHALL come directly from stage DEPTH-1 registers (no combinational path from D).
REQ-024 Q SHALL hold its value while OUT_VALID && !OUT_READY.
REQ-025 When S=1 and C=0: every stage with valid=1 after this cycle's movement SHALL hold SET_VAL; valid bits unchanged; an entry accepted this cycle is also overwritten with SET_VAL.
REQ-026 When C=1: all valid bits SHALL be 0 after the edge, IN_READY SHALL still be driven per REQ-019 but any accepted entry is discarded; data registers keep their values.
REQ-027 S and C both 1: C SHALL take priority.
REQ-028 OCC SHALL equal the count of set valid bits, updated registered; range 0..DEPTH; OCC=DEPTH implies IN_READY = OUT_READY.
REQ-029 DEPTH=1 SHALL behave as a single-entry register slice with IN_READY = !OUT_VALID || OUT_READY.

Reset
REQ-030 R=1 SHALL immediately, independent of CLK, force all data registers to RST_VAL, all valid bits to 0, OCC to 0, Q to RST_VAL, OUT_VALID to 0.
REQ-031 While R=1, IN_READY SHALL be 0 and D, S, C SHALL be ignored.
REQ-032 R asserted mid-transfer SHALL discard all entries; first accepted entry after R falls SHALL be the first observed at Q.
REQ-033 R deassertion SHALL take effect at the next rising CLK edge without glitching outputs.

Verification (WIDTH=8, DEPTH=2, RST_VAL=0x00, SET_VAL=0xFF)
REQ-034 Stream: R pulse, OUT_READY=1, send 0x11,0x22,0x33 back-to-back -> Q=0x11 with OUT_VALID 2 cycles after first transfer, then 0x22, 0x33 consecutive, OCC never >2.
REQ-035 Backpressure: OUT_READY=0, send 0xA1,0xA2,0xA3 -> two accepted, IN_READY=0, OCC=2, Q=0xA1 stable; raise OUT_READY -> 0xA1, 0xA2, 0xA3 in order.
REQ-036 Set: pipe holds 0x05,0x06, pulse S one cycle with OUT_READY=0 -> both stages 0xFF, OCC=2; empty pipe plus S -> OCC stays 0.
REQ-037 Clear priority: pipe holds 2 entries, S=C=1 with IN_VALID=1 D=0x77 -> OCC=0, OUT_VALID=0 next cycle, 0x77 never appears at Q.
REQ-038 Async reset: pipe full, assert R between clock edges -> Q=0x00, OUT_VALID=0, OCC=0, IN_READY=0 before next edge; after release, send 0x42 -> Q=0x42 after 2 cycles.
